// File: rtl/result_drain.sv
// rtl/result_drain.sv - streams a captured 4x4 result matrix one element per transfer.
// Optional sticky overrun flag when RESULT_DRAIN_OVERRUN_EN is defined.
module result_drain #(
  parameter int COLMAJOR = 0
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic [3:0][3:0][15:0]  i_c,
  input  logic                   i_validResult,
  output logic [15:0]            o_data,
  output logic [1:0]             o_row,
  output logic [1:0]             o_col,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_last,
  output logic                   o_busy
`ifdef RESULT_DRAIN_OVERRUN_EN
  ,
  output logic                   o_overrun
`endif
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]            state;
  logic [3:0]            k;
  logic [3:0][3:0][15:0] buffer;
  logic [1:0]            row_idx;
  logic [1:0]            col_idx;
  logic                  streaming;
  logic                  xfer;
  logic                  final_xfer;

  assign streaming  = (state == STREAM);
  assign xfer       = streaming && i_ready;
  assign final_xfer = xfer && (k == 4'd15);

  always_comb begin
    row_idx = k[3:2];
    col_idx = k[1:0];
    if (COLMAJOR != 0) begin
      row_idx = k[1:0];
      col_idx = k[3:2];
    end
  end

  // State is a flop, so valid/busy are registered; payload is forced to 0 in IDLE.
  assign o_valid = streaming;
  assign o_busy  = streaming;
  assign o_row   = streaming ? row_idx : 2'd0;
  assign o_col   = streaming ? col_idx : 2'd0;
  assign o_data  = streaming ? buffer[row_idx][col_idx] : 16'd0;
  assign o_last  = streaming && (k == 4'd15);

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state  <= IDLE;
      k      <= 4'd0;
      buffer <= '0;
    end else if (state == IDLE) begin
      if (i_validResult) begin
        buffer <= i_c;
        k      <= 4'd0;
        state  <= STREAM;
      end
    end else if (xfer) begin
      // k wraps 15 -> 0 naturally, which also serves the back-to-back restart.
      k <= k + 4'd1;
      if (k == 4'd15) begin
        if (i_validResult) begin
          buffer <= i_c;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

`ifdef RESULT_DRAIN_OVERRUN_EN
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      o_overrun <= 1'b0;
    end else if (streaming && i_validResult && !final_xfer) begin
      o_overrun <= 1'b1;
    end
  end
`endif

endmodule
